fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the five-stage pipeline CPU. Owns the program counter, drives the fetch address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register for decode. Handles stall from the hazard unit and redirect (branch/jump taken) from EX, inserting NOP bubbles on flush.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INST, 32'h0000_0013, bubble word (addi x0,x0,0)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock, synchronous, active-high
- stall_if  input  1  hold PC and IF/ID contents (load-use hazard)
- redirect_valid  input  1  taken branch/jump resolved in EX
- redirect_pc  input  32  redirect target byte address
- pc  output  32  fetch address to instruction memory (registered PC)
- instruction  input  32  word returned combinationally by instruction memory for `pc`
- if_id_pc  output  32  PC of the instruction held in IF/ID
- if_id_pc_plus4  output  32  if_id_pc + 4 (for jal/jalr link)
- if_id_instruction  output  32  instruction held in IF/ID
- if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
- fetch_misalign  output  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- PC register next-value priority: rst > redirect_valid > stall_if > halted > pc+4.
- redirect_valid: PC <= redirect_pc; IF/ID <= bubble (wrong-path instruction in IF discarded). Redirect overrides a simultaneous stall_if.
- stall_if (no redirect): PC and all IF/ID outputs hold unchanged.
- Normal: PC <= pc+4; IF/ID <= {pc, pc+4, instruction, valid=1}.
- Bubble: if_id_instruction=NOP_INST, if_id_valid=0, if_id_pc/if_id_pc_plus4 hold the discarded PC and PC+4.
- State machine (only meaningful with IF_MISALIGN_TRAP_EN): RUN, HALT. RUN -> HALT on redirect with redirect_pc[1:0]!=0; HALT -> RUN on aligned redirect; rst -> RUN. In HALT, PC holds, IF/ID loads bubbles every cycle.
- Arithmetic: 32-bit unsigned, pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.

## Timing
- Reset values: pc=RESET_PC, if_id_pc=RESET_PC, if_id_pc_plus4=RESET_PC+4, if_id_instruction=NOP_INST, if_id_valid=0, fetch_misalign=0, state RUN.
- First valid instruction appears in IF/ID one cycle after rst deasserts.
- Fetch latency: word at `pc` in cycle N is in IF/ID at cycle N+1.
- Redirect penalty: redirect asserted cycle N -> pc=redirect_pc cycle N+1, bubble in IF/ID cycle N+1, target instruction in IF/ID cycle N+2.
- rst during stall or redirect: reset wins; all state returns to reset values next edge.
- Stall held for multiple cycles: no change in any output for the duration.

## Configuration
- IF_MISALIGN_TRAP_EN defined: redirect to non-word-aligned target sets fetch_misalign (sticky until rst or aligned redirect), PC loads the misaligned target unchanged for debug, FSM enters HALT.
- Not defined: redirect_pc[1:0] forced to 2'b00 on load, no HALT state, fetch_misalign tied 0.

## Structure
- Shared package riscv_pkg: NOP_INST constant, RESET_PC default, fetch-state enum (RUN/HALT), XLEN=32.
- One sub-module: if_id_reg — the IF/ID pipeline register with load/hold/bubble control; fetch_stage holds PC, FSM and next-PC mux.

## Test plan
- Reset then run 4 cycles, imem returns 32'h1000_0000+pc -> pc 0,4,8,12; if_id_pc 0,4,8 with if_id_valid=1, if_id_pc_plus4=if_id_pc+4.
- stall_if high 3 cycles at pc=8 -> pc stays 8, IF/ID stays {pc=4, valid=1} for 3 cycles, then resumes at 8.
- redirect_valid with redirect_pc=32'h40 at pc=12 -> next cycle pc=0x40, if_id_valid=0, if_id_instruction=32'h0000_0013; following cycle if_id_pc=0x40 valid.
- redirect_valid and stall_if same cycle, target 0x80 -> pc=0x80, bubble in IF/ID.
- IF_MISALIGN_TRAP_EN, redirect to 0x42 -> fetch_misalign=1, if_id_valid=0 every cycle; redirect to 0x44 clears it, 0x44 valid one cycle later. Without macro: pc=0x40.
- rst asserted mid-stall at pc=0x20 -> next cycle pc=RESET_PC, if_id_valid=0, fetch_misalign=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline constants, fetch-state encoding and PC helper
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  // Sequential successor address; wraps silently at the top of the address space
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc_in);
    return pc_in + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and bubble control
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_bubble,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus4,
  input  logic [XLEN-1:0] i_instruction,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_instruction,
  output logic            o_valid
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic [XLEN-1:0] r_instruction;
  logic            r_valid;

  // Bubble keeps the discarded PC for debug visibility but replaces the word with a NOP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_pc_plus4    <= pc_plus4(RESET_PC);
      r_instruction <= NOP_INST;
      r_valid       <= 1'b0;
    end else if (i_bubble) begin
      r_pc          <= i_pc;
      r_pc_plus4    <= i_pc_plus4;
      r_instruction <= NOP_INST;
      r_valid       <= 1'b0;
    end else if (i_load) begin
      r_pc          <= i_pc;
      r_pc_plus4    <= i_pc_plus4;
      r_instruction <= i_instruction;
      r_valid       <= 1'b1;
    end
  end

  assign o_pc          = r_pc;
  assign o_pc_plus4    = r_pc_plus4;
  assign o_instruction = r_instruction;
  assign o_valid       = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, next-PC mux and fetch FSM (optional IF_MISALIGN_TRAP_EN)
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_if,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [XLEN-1:0] if_id_instruction,
  output logic            if_id_valid,
  output logic            fetch_misalign
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_redirect_target;
  logic            w_halted;
  logic            w_bubble;
  logic            w_load;

  assign w_pc_plus4 = pc_plus4(r_pc);

`ifdef IF_MISALIGN_TRAP_EN
  localparam logic [0:0] ST_RUN  = FETCH_RUN;
  localparam logic [0:0] ST_HALT = FETCH_HALT;

  logic [0:0] r_state;
  logic       r_misalign;
  logic       w_redirect_misaligned;

  // Misaligned target is loaded as-is so a debugger can see where control went
  assign w_redirect_target     = redirect_pc;
  assign w_redirect_misaligned = |redirect_pc[1:0];
  assign w_halted              = (r_state == ST_HALT);

  // Every redirect re-decides RUN/HALT; the flag follows the alignment of the latest target
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_state    <= w_redirect_misaligned ? ST_HALT : ST_RUN;
      r_misalign <= w_redirect_misaligned;
    end
  end

  assign fetch_misalign = r_misalign;
`else
  logic [1:0] w_unused_redirect_lsbs;

  // Without the trap, targets are word-aligned by dropping the low bits
  assign w_redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_redirect_lsbs = redirect_pc[1:0];
  assign w_halted               = 1'b0;
  assign fetch_misalign         = 1'b0;
`endif

  // Redirect squashes the wrong-path word; a halted fetch keeps emitting bubbles unless stalled
  assign w_bubble = redirect_valid | (w_halted & ~stall_if);
  assign w_load   = ~stall_if & ~w_halted;

  // Next-PC priority: reset, redirect, stall, halt, sequential
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_target;
    end else if (!stall_if && !w_halted) begin
      r_pc <= w_pc_plus4;
    end
  end

  assign pc = r_pc;

  if_id_reg #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_bubble      (w_bubble),
    .i_pc          (r_pc),
    .i_pc_plus4    (w_pc_plus4),
    .i_instruction (instruction),
    .o_pc          (if_id_pc),
    .o_pc_plus4    (if_id_pc_plus4),
    .o_instruction (if_id_instruction),
    .o_valid       (if_id_valid)
  );

endmodule
